// File: rtl/cdc_addr_decoder.sv
// Registered address decoder for the FIR block's host port. It splits the CDC address
// space into a RAM region (MSB=0) and a register-file region (MSB=1).
module cdc_addr_decoder #(
    parameter int ADDR_W = 6,
    parameter int RAM_AW = 5,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] CDC_A,
    input  logic              CDC_wr,
    output logic              Dekoder_MUX,
    output logic [RAM_AW-1:0] address_RAM,
    output logic              wr_RAM,
    output logic [REG_AW-1:0] nr_Rejestru,
    output logic              wr_Rej,
    output logic              addr_err
);

    logic              sel;
    logic              slot_ok;
    logic [RAM_AW-1:0] ram_off;

    logic              mux_q,   mux_d;
    logic [RAM_AW-1:0] ram_a_q, ram_a_d;
    logic              wr_ram_q, wr_ram_d;
    logic [REG_AW-1:0] reg_n_q, reg_n_d;
    logic              wr_rej_q, wr_rej_d;
    logic              err_q,   err_d;

    assign sel     = CDC_A[ADDR_W-1];
    assign ram_off = CDC_A[RAM_AW-1:0];
    // The shift also covers REG_AW == RAM_AW, where every register slot is implemented.
    assign slot_ok = ((ram_off >> REG_AW) == '0);

    always_comb begin
        mux_d    = sel;
        ram_a_d  = ram_off;
        reg_n_d  = CDC_A[REG_AW-1:0];
        wr_ram_d = CDC_wr & ~sel;
        wr_rej_d = CDC_wr & sel & slot_ok;
        err_d    = sel & ~slot_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_q    <= 1'b0;
            ram_a_q  <= '0;
            wr_ram_q <= 1'b0;
            reg_n_q  <= '0;
            wr_rej_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mux_q    <= mux_d;
            ram_a_q  <= ram_a_d;
            wr_ram_q <= wr_ram_d;
            reg_n_q  <= reg_n_d;
            wr_rej_q <= wr_rej_d;
            err_q    <= err_d;
        end
    end

    assign Dekoder_MUX = mux_q;
    assign address_RAM = ram_a_q;
    assign wr_RAM      = wr_ram_q;
    assign nr_Rejestru = reg_n_q;
    assign wr_Rej      = wr_rej_q;
    assign addr_err    = err_q;

endmodule

// File: tb/tb_cdc_addr_decoder.sv
// Bench for cdc_addr_decoder: directed literal cases plus random traffic against an
// arithmetic decode model. The model's outputs are compared on every falling edge.
module tb_cdc_addr_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] CDC_A = '0;
    logic       CDC_wr = 1'b0;
    logic       Dekoder_MUX, wr_RAM, wr_Rej, addr_err;
    logic [4:0] address_RAM;
    logic [2:0] nr_Rejestru;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int e_mux = 0, e_ram = 0, e_wram = 0, e_reg = 0, e_wrej = 0, e_err = 0;

    cdc_addr_decoder #(.ADDR_W(6), .RAM_AW(5), .REG_AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .CDC_A(CDC_A), .CDC_wr(CDC_wr),
        .Dekoder_MUX(Dekoder_MUX), .address_RAM(address_RAM), .wr_RAM(wr_RAM),
        .nr_Rejestru(nr_Rejestru), .wr_Rej(wr_Rej), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: decode written as plain arithmetic on the integer address.
    always @(posedge clk or negedge rst_n) begin
        int a;
        int w;
        if (!rst_n) begin
            e_mux <= 0; e_ram <= 0; e_wram <= 0; e_reg <= 0; e_wrej <= 0; e_err <= 0;
        end else begin
            a = int'(CDC_A);
            w = int'(CDC_wr);
            e_mux  <= (a >= 32) ? 1 : 0;
            e_ram  <= a % 32;
            e_reg  <= a % 8;
            e_wram <= (w == 1 && a < 32) ? 1 : 0;
            e_wrej <= (w == 1 && a >= 32 && a < 40) ? 1 : 0;
            e_err  <= (a >= 40) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("mdl_mux",  int'(Dekoder_MUX), e_mux);
            cmp("mdl_ram",  int'(address_RAM), e_ram);
            cmp("mdl_wram", int'(wr_RAM),      e_wram);
            cmp("mdl_reg",  int'(nr_Rejestru), e_reg);
            cmp("mdl_wrej", int'(wr_Rej),      e_wrej);
            cmp("mdl_err",  int'(addr_err),    e_err);
            cmp("mutex",    int'(wr_RAM & wr_Rej), 0);
        end
    end

    // Called at a falling edge; returns at the next falling edge with outputs valid.
    task automatic apply(input logic [5:0] a, input logic w);
        CDC_A  = a;
        CDC_wr = w;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_mux"},  int'(Dekoder_MUX), 0);
        cmp({tag, "_ram"},  int'(address_RAM), 0);
        cmp({tag, "_wram"}, int'(wr_RAM),      0);
        cmp({tag, "_reg"},  int'(nr_Rejestru), 0);
        cmp({tag, "_wrej"}, int'(wr_Rej),      0);
        cmp({tag, "_err"},  int'(addr_err),    0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("rst0");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        apply(6'b000101, 1'b1);
        cmp("ramwr_mux", int'(Dekoder_MUX), 0);
        cmp("ramwr_ram", int'(address_RAM), 5);
        cmp("ramwr_wr",  int'(wr_RAM), 1);
        cmp("ramwr_reg", int'(nr_Rejestru), 5);
        cmp("ramwr_wrej", int'(wr_Rej), 0);
        cmp("ramwr_err", int'(addr_err), 0);

        apply(6'b000111, 1'b0);
        cmp("ramrd_mux", int'(Dekoder_MUX), 0);
        cmp("ramrd_ram", int'(address_RAM), 7);
        cmp("ramrd_wr",  int'(wr_RAM), 0);
        cmp("ramrd_reg", int'(nr_Rejestru), 7);
        cmp("ramrd_wrej", int'(wr_Rej), 0);

        apply(6'b100011, 1'b1);
        cmp("regwr_mux", int'(Dekoder_MUX), 1);
        cmp("regwr_ram", int'(address_RAM), 3);
        cmp("regwr_wram", int'(wr_RAM), 0);
        cmp("regwr_reg", int'(nr_Rejestru), 3);
        cmp("regwr_wrej", int'(wr_Rej), 1);

        apply(6'b100001, 1'b0);
        cmp("regrd_mux", int'(Dekoder_MUX), 1);
        cmp("regrd_reg", int'(nr_Rejestru), 1);
        cmp("regrd_wrej", int'(wr_Rej), 0);

        apply(6'b011111, 1'b1);
        cmp("last_mux", int'(Dekoder_MUX), 0);
        cmp("last_ram", int'(address_RAM), 31);
        cmp("last_wr",  int'(wr_RAM), 1);

        apply(6'b101010, 1'b1);
        cmp("bad_mux",  int'(Dekoder_MUX), 1);
        cmp("bad_wrej", int'(wr_Rej), 0);
        cmp("bad_wram", int'(wr_RAM), 0);
        cmp("bad_err",  int'(addr_err), 1);

        apply(6'h1F, 1'b1);
        cmp("b2b0_wram", int'(wr_RAM), 1);
        cmp("b2b0_ram",  int'(address_RAM), 31);
        apply(6'h20, 1'b1);
        cmp("b2b1_wrej", int'(wr_Rej), 1);
        cmp("b2b1_reg",  int'(nr_Rejestru), 0);
        cmp("b2b1_wram", int'(wr_RAM), 0);
        apply(6'h27, 1'b1);
        cmp("b2b2_wrej", int'(wr_Rej), 1);
        cmp("b2b2_reg",  int'(nr_Rejestru), 7);
        cmp("b2b2_err",  int'(addr_err), 0);

        // Asynchronous reset between clock edges while a strobe is pending.
        CDC_A  = 6'h05;
        CDC_wr = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("arst");
        @(negedge clk);
        check_all_zero("arst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        cmp("rel_ram", int'(address_RAM), 5);
        cmp("rel_wr",  int'(wr_RAM), 1);

        for (int i = 0; i < 400; i++) begin
            apply(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
